// File: rtl/dsp_task_scheduler.sv
// rtl/dsp_task_scheduler.sv - per-period DSP engine sequencer with result-write multiplexer
module dsp_task_scheduler #(
    parameter int ENGINES     = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int RUN_TIMEOUT = 4095
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  trigger_i,
    input  logic [ENGINES-1:0]    engine_mask_i,
    input  logic                  clear_i,
    input  logic [ENGINES-1:0]    wip_i,
    output logic [ENGINES-1:0]    enable_o,
    input  logic [ENGINES-1:0]    mem_we_i,
    input  logic [ENGINES*9-1:0]  mem_addrw_i,
    input  logic [ENGINES*36-1:0] mem_data_i,
    output logic                  mem_we_o,
    output logic [8:0]            mem_addrw_o,
    output logic [35:0]           mem_data_o,
    output logic                  busy_o,
    output logic [1:0]            active_o,
    output logic                  done_o,
    output logic                  overrun_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_NEXT} state_t;

    state_t               r_state;
    logic [ENGINES-1:0]   r_pending;
    logic [ENGINES-1:0]   r_enable;
    logic [1:0]           r_idx;
    logic [15:0]          r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;
    logic                 r_timeout;
    logic                 r_mem_we;
    logic [8:0]           r_mem_addrw;
    logic [35:0]          r_mem_data;

    logic                 w_wip;
    logic                 w_we;
    logic [8:0]           w_addrw;
    logic [35:0]          w_data;
    logic [ENGINES-1:0]   w_remaining;
    logic [1:0]           w_first;
    logic [1:0]           w_next_idx;
    logic                 w_ack_expire;
    logic                 w_run_expire;
    logic                 w_timeout_evt;
    logic                 w_in_slot;

    function automatic logic [1:0] lowest(input logic [ENGINES-1:0] m);
        lowest = '0;
        for (int k = ENGINES - 1; k >= 0; k--) begin
            if (m[k]) lowest = 2'(k);
        end
    endfunction

    function automatic logic [ENGINES-1:0] onehot(input logic [1:0] i);
        onehot = '0;
        for (int k = 0; k < ENGINES; k++) begin
            if (i == 2'(k)) onehot[k] = 1'b1;
        end
    endfunction

    // Select the active engine's handshake and write port.
    always_comb begin
        w_wip   = 1'b0;
        w_we    = 1'b0;
        w_addrw = '0;
        w_data  = '0;
        for (int k = 0; k < ENGINES; k++) begin
            if (r_idx == 2'(k)) begin
                w_wip   = wip_i[k];
                w_we    = mem_we_i[k];
                w_addrw = mem_addrw_i[9*k +: 9];
                w_data  = mem_data_i[36*k +: 36];
            end
        end
    end

    assign w_remaining   = r_pending & ~onehot(r_idx);
    assign w_first       = lowest(engine_mask_i);
    assign w_next_idx    = lowest(w_remaining);
    assign w_ack_expire  = (r_cnt == 16'(ACK_TIMEOUT - 1));
    assign w_run_expire  = (r_cnt == 16'(RUN_TIMEOUT - 1));
    assign w_timeout_evt = ((r_state == S_START) && !w_wip && w_ack_expire) ||
                           ((r_state == S_RUN) && w_wip && w_run_expire);
    assign w_in_slot     = (r_state == S_START) || (r_state == S_RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_enable    <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addrw <= '0;
            r_mem_data  <= '0;
        end else begin
            r_done    <= 1'b0;
            // Set events beat a simultaneous clear.
            r_overrun <= (trigger_i && r_busy) || (r_overrun && !clear_i);
            r_timeout <= w_timeout_evt || (r_timeout && !clear_i);

            r_mem_we <= w_in_slot && w_we;
            if (w_in_slot) begin
                r_mem_addrw <= w_addrw;
                r_mem_data  <= w_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (trigger_i && (engine_mask_i != '0)) begin
                        r_pending <= engine_mask_i;
                        r_idx     <= w_first;
                        r_enable  <= onehot(w_first);
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_wip) begin
                        r_enable <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end else if (w_ack_expire) begin
                        r_enable <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!w_wip || w_run_expire) begin
                        r_cnt   <= '0;
                        r_state <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_pending <= w_remaining;
                    r_cnt     <= '0;
                    if (w_remaining != '0) begin
                        r_idx    <= w_next_idx;
                        r_enable <= onehot(w_next_idx);
                        r_state  <= S_START;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign enable_o    = r_enable;
    assign mem_we_o    = r_mem_we;
    assign mem_addrw_o = r_mem_addrw;
    assign mem_data_o  = r_mem_data;
    assign busy_o      = r_busy;
    assign active_o    = r_idx;
    assign done_o      = r_done;
    assign overrun_o   = r_overrun;
    assign timeout_o   = r_timeout;

endmodule

// File: doc/dsp_task_scheduler.md
Name: dsp_task_scheduler

Overview:
- Sequences the shared-clock DSP engines (Kalman filter, resonant grid controller) once per control period.
- On each period trigger (derived from Local_counter sync_phase), starts every enabled engine in turn, lowest index first. It waits for each engine's WIP flag to rise and then fall before starting the next.
- Multiplexes the engines' Mem2 result-write ports onto one result-memory write port.
- Reports completion, overrun and timeout to the EMIF status registers.

Parameters:
- ENGINES, 2: number of engines scheduled; legal range 1..4; index 0 has highest priority.
- ACK_TIMEOUT, 16: maximum cycles in START waiting for wip_i to rise.
- RUN_TIMEOUT, 4095: maximum cycles in RUN waiting for wip_i to fall; range 1..65535.

Ports:
- clk_i  in  1  DSP clock; single clock domain.
- rst_i  in  1  synchronous reset, active-high.
- trigger_i  in  1  one-cycle period-start pulse, already synchronous to clk_i.
- engine_mask_i  in  ENGINES  engines to run this period; sampled on trigger.
- clear_i  in  1  clears the sticky flags.
- wip_i  in  ENGINES  engine WIP_flag_o inputs.
- enable_o  out  ENGINES  engine enable_i drives.
- mem_we_i  in  ENGINES  engine Mem2_we_o.
- mem_addrw_i  in  ENGINES*9  engine Mem2_addrw_o, concatenated; engine k occupies [9k+8:9k].
- mem_data_i  in  ENGINES*36  engine Mem2_data_o, concatenated; engine k occupies [36k+35:36k].
- mem_we_o  out  1  muxed write enable.
- mem_addrw_o  out  9  muxed write address.
- mem_data_o  out  36  muxed write data.
- busy_o  out  1  high when the FSM is not in IDLE.
- active_o  out  2  index of the current engine.
- done_o  out  1  one-cycle pulse when the sequence finishes.
- overrun_o  out  1  sticky: a trigger arrived while busy.
- timeout_o  out  1  sticky: an ACK or RUN timeout occurred.

Behaviour:
- Reset:
  - State goes to IDLE; all outputs are 0, including enable_o, mem_we_o, the sticky flags and the counters.
  - Reset mid-sequence drops enable_o and mem_we_o at the same edge; the pending mask is discarded.
- FSM states: IDLE, START, RUN, NEXT. All outputs are registered.
- IDLE:
  - trigger_i=1 with engine_mask_i≠0: latch mask into pending; idx = lowest set bit; go to START.
  - trigger_i=1 with engine_mask_i=0: ignored; no done_o pulse.
- START:
  - enable_o[idx]=1, all other enable_o bits 0. enable_o rises in the cycle after trigger_i.
  - wip_i[idx]=1: go to RUN.
  - ACK counter reaches ACK_TIMEOUT: set timeout_o, go to NEXT.
- RUN:
  - enable_o = 0.
  - wip_i[idx]=0: go to NEXT.
  - RUN counter reaches RUN_TIMEOUT: set timeout_o, go to NEXT.
  - Counters reset on every state entry.
- NEXT:
  - Clear pending[idx].
  - Remaining pending≠0: idx = next lowest set bit; go to START.
  - Otherwise: go to IDLE; done_o=1 for exactly that cycle; busy_o falls in the same cycle.
- Latency, one engine, wip_i rising 1 cycle after enable: trigger at cycle 0 → enable_o at 1 → RUN at 3.
- Overrun:
  - trigger_i while busy_o=1 sets overrun_o; the trigger is dropped.
  - The running sequence is unaffected.
- Sticky flags:
  - Cleared by clear_i.
  - A set event in the same cycle as clear_i wins: the flag ends up 1.
- Write mux:
  - In START or RUN: mem_*_o = engine idx's port, registered, 1-cycle latency.
  - In IDLE or NEXT: mem_we_o=0; mem_addrw_o and mem_data_o hold their last values.
  - Writes from non-active engines are dropped silently.
- active_o:
  - Holds idx; idx is zero-extended to 2 bits.
  - active_o keeps its last value while in IDLE.

Test Plan:
- Basic sequence: ENGINES=2, mask=2'b11, each wip_i rises 2 cycles after enable and stays high 10 cycles → enable_o[0] then enable_o[1], no overlap; single done_o pulse; busy_o low afterwards; timeout_o=0.
- Write mux: engine 0 writes addr 9'h005 / data 36'h123456789 during its RUN, engine 1 writes addr 9'h1FF at the same time → mem_addrw_o=9'h005 and data appear 1 cycle later; the engine-1 write never appears.
- Skipped engine: mask=2'b10 → enable_o[0] never asserts; engine 1 runs; done_o pulses once; active_o=1.
- Timeouts: wip_i[0] stuck 0 → after 16 START cycles timeout_o=1 and engine 1 starts. Separately, wip_i[1] stuck 1 with RUN_TIMEOUT=100 → leaves RUN after 100 cycles; done_o pulses.
- Overrun and clear: trigger_i pulses while busy → overrun_o=1, sequence unchanged. clear_i together with a new overrun → overrun_o stays 1; clear_i alone → 0.
- Reset mid-RUN: rst_i asserted → enable_o=0, mem_we_o=0, busy_o=0 at the next edge. A later trigger restarts the sequence from engine 0.
